peripheral_dma_ahb3_master_arbiter: RTL and testbench



---
 rtl/peripheral_dma_ahb3_master_arbiter_pkg.sv | 30 +++
 rtl/peripheral_dma_ahb3_master_arbiter_rr.sv | 39 +++
 rtl/peripheral_dma_ahb3_master_arbiter.sv | 128 ++++++++++++
 tb/tb_peripheral_dma_ahb3_master_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_dma_ahb3_master_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peripheral_dma_ahb3_master_arbiter_pkg                                    |
// | AHB3-Lite constants and DMA master-arbiter FSM state type.                |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package peripheral_dma_ahb3_master_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE      = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ    = 2'b10;
  localparam logic [2:0] HBURST_SINGLE    = 3'b000;
  localparam logic [2:0] HSIZE_BYTE       = 3'b000;
  localparam logic [3:0] HPROT_DATA       = 4'b0001;
  localparam logic [3:0] HPROT_PRIVILEGED = 4'b0010;
  localparam logic       HRESP_ERROR      = 1'b1;
  localparam logic [3:0] HPROT_DMA        = HPROT_DATA | HPROT_PRIVILEGED;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } dma_ahb_state_t;

  function automatic int rr_wrap(input int value, input int modulus);
    return (value >= modulus) ? value - modulus : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_dma_ahb3_master_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peripheral_dma_arbiter_rr                                                 |
// | Combinational round-robin arbiter: first request after the last grant.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module peripheral_dma_arbiter_rr
  import peripheral_dma_ahb3_master_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int IDX_W      = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] i_req,
  input  logic [IDX_W-1:0]      i_last,
  output logic [REQUESTERS-1:0] o_gnt,
  output logic [IDX_W-1:0]      o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Scan starts one past the last grant so the last winner has lowest priority.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      w_cand = IDX_W'(rr_wrap(int'(i_last) + i, REQUESTERS));
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/peripheral_dma_ahb3_master_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peripheral_dma_ahb3_master_arbiter                                        |
// | Round-robin sharing of one AHB3-Lite master port, one SINGLE at a time.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module peripheral_dma_ahb3_master_arbiter
  import peripheral_dma_ahb3_master_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int HADDR_SIZE = 64,
  parameter int HDATA_SIZE = 64
) (
  input  logic                             HRESETn,
  input  logic                             HCLK,
  input  logic [REQUESTERS-1:0]            req_i,
  input  logic [REQUESTERS-1:0]            req_we_i,
  input  logic [REQUESTERS*HADDR_SIZE-1:0] req_addr_i,
  input  logic [REQUESTERS*3-1:0]          req_size_i,
  input  logic [REQUESTERS*HDATA_SIZE-1:0] req_wdata_i,
  output logic [REQUESTERS-1:0]            ack_o,
  output logic [HDATA_SIZE-1:0]            rdata_o,
  output logic                             err_o,
  output logic                             HSEL,
  output logic [HADDR_SIZE-1:0]            HADDR,
  output logic [HDATA_SIZE-1:0]            HWDATA,
  input  logic [HDATA_SIZE-1:0]            HRDATA,
  output logic                             HWRITE,
  output logic [2:0]                       HSIZE,
  output logic [2:0]                       HBURST,
  output logic [3:0]                       HPROT,
  output logic [1:0]                       HTRANS,
  output logic                             HMASTLOCK,
  input  logic                             HREADY,
  input  logic                             HRESP
);

  localparam int IDX_W = $clog2(REQUESTERS);

  dma_ahb_state_t          r_state;
  dma_ahb_state_t          w_state_nxt;
  logic [IDX_W-1:0]        r_ptr;
  logic [REQUESTERS-1:0]   r_gnt;
  logic [HADDR_SIZE-1:0]   r_addr;
  logic                    r_we;
  logic [2:0]              r_size;
  logic [HDATA_SIZE-1:0]   r_wdata;
  logic [HDATA_SIZE-1:0]   r_rdata;
  logic                    r_err;
  logic [REQUESTERS-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_any_req;
  logic                    w_grant;

  peripheral_dma_arbiter_rr #(
    .REQUESTERS (REQUESTERS),
    .IDX_W      (IDX_W)
  ) u_arbiter (
    .i_req  (req_i),
    .i_last (r_ptr),
    .o_gnt  (w_arb_gnt),
    .o_idx  (w_arb_idx)
  );

  assign w_any_req = |req_i;
  assign w_grant   = (r_state == ST_IDLE) && w_any_req;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RESP always returns to IDLE without looking at req_i.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_nxt = ST_ADDR;
      ST_ADDR: if (HREADY)    w_state_nxt = ST_DATA;
      ST_DATA: if (HREADY)    w_state_nxt = ST_RESP;
      ST_RESP:                w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ptr   <= IDX_W'(REQUESTERS - 1);
      r_gnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_size  <= HSIZE_BYTE;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ptr   <= w_arb_idx;
        r_gnt   <= w_arb_gnt;
        r_addr  <= req_addr_i[int'(w_arb_idx)*HADDR_SIZE +: HADDR_SIZE];
        r_we    <= req_we_i[w_arb_idx];
        r_size  <= req_size_i[int'(w_arb_idx)*3 +: 3];
        r_wdata <= req_wdata_i[int'(w_arb_idx)*HDATA_SIZE +: HDATA_SIZE];
      end
      if ((r_state == ST_DATA) && HREADY) begin
        r_err <= (HRESP == HRESP_ERROR);
        if (!r_we) r_rdata <= HRDATA;
      end
    end
  end

  assign HSEL      = (r_state == ST_ADDR);
  assign HTRANS    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = r_addr;
  assign HWDATA    = r_wdata;
  assign HWRITE    = r_we;
  assign HSIZE     = r_size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DMA;
  assign HMASTLOCK = 1'b0;
  assign ack_o     = (r_state == ST_RESP) ? r_gnt : '0;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_dma_ahb3_master_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_peripheral_dma_ahb3_master_arbiter                                     |
// | Directed plus random transfers against a round-robin bus-transfer model.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_peripheral_dma_ahb3_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            HRESETn;
  logic            HCLK;
  logic [N-1:0]    req_i;
  logic [N-1:0]    req_we_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*3-1:0]  req_size_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    ack_o;
  logic [DW-1:0]   rdata_o;
  logic            err_o;
  logic            HSEL;
  logic [AW-1:0]   HADDR;
  logic [DW-1:0]   HWDATA;
  logic [DW-1:0]   HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HRESP;

  peripheral_dma_ahb3_master_arbiter #(
    .REQUESTERS (N),
    .HADDR_SIZE (AW),
    .HDATA_SIZE (DW)
  ) dut (
    .HRESETn     (HRESETn),
    .HCLK        (HCLK),
    .req_i       (req_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_size_i  (req_size_i),
    .req_wdata_i (req_wdata_i),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HWDATA      (HWDATA),
    .HRDATA      (HRDATA),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HTRANS      (HTRANS),
    .HMASTLOCK   (HMASTLOCK),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  longint cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int            checks   = 0;
  int            failures = 0;
  int            last_grant;
  logic [DW-1:0] exp_rdata;
  longint        last_ack_cyc;
  logic          m_we    [N];
  logic [AW-1:0] m_addr  [N];
  logic [2:0]    m_size  [N];
  logic [DW-1:0] m_wdata [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_grant(input logic [N-1:0] pending, input int last);
    for (int i = 1; i <= N; i++) begin
      if (pending[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic add_req(input int k, input logic we, input logic [AW-1:0] addr,
                         input logic [2:0] size, input logic [DW-1:0] wd);
    m_we[k] = we; m_addr[k] = addr; m_size[k] = size; m_wdata[k] = wd;
    req_we_i[k]             = we;
    req_addr_i[k*AW +: AW]  = addr;
    req_size_i[k*3 +: 3]    = size;
    req_wdata_i[k*DW +: DW] = wd;
    req_i[k]                = 1'b1;
  endtask

  task automatic add_random_req(input int k);
    add_req(k, 1'($urandom_range(0, 1)), {$urandom, $urandom},
            3'($urandom_range(0, 3)), {$urandom, $urandom});
  endtask

  task automatic check_addr_phase(input int g);
    check("addr_htrans", 64'(HTRANS), 64'(2'b10));
    check("addr_hsel", 64'(HSEL), 64'd1);
    check("addr_haddr", HADDR, m_addr[g]);
    check("addr_hwrite", 64'(HWRITE), 64'(m_we[g]));
    check("addr_hsize", 64'(HSIZE), 64'(m_size[g]));
    check("addr_hburst", 64'(HBURST), 64'd0);
    check("hprot", 64'(HPROT), 64'h3);
    check("hmastlock", 64'(HMASTLOCK), 64'd0);
    check("addr_ack", 64'(ack_o), 64'd0);
  endtask

  task automatic check_data_phase(input int g);
    check("data_htrans", 64'(HTRANS), 64'd0);
    check("data_hsel", 64'(HSEL), 64'd0);
    if (m_we[g]) check("data_hwdata", HWDATA, m_wdata[g]);
    check("data_ack", 64'(ack_o), 64'd0);
  endtask

  // Called at a negedge in an IDLE cycle with at least one request pending.
  task automatic xfer(input int aw, input int dw_in, input logic err,
                      input logic [DW-1:0] hrd, input bit check_spacing);
    int g;
    int dw;
    dw = (err && dw_in < 1) ? 1 : dw_in;
    g = next_grant(req_i, last_grant);
    if (g < 0) begin
      checks++;
      failures++;
      $display("FAIL no_request observed=0 expected=nonzero");
      return;
    end
    @(posedge HCLK); @(negedge HCLK);
    for (int i = 0; i < aw; i++) begin
      HREADY = 1'b0;
      check_addr_phase(g);
      @(posedge HCLK); @(negedge HCLK);
    end
    check_addr_phase(g);
    HREADY = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    for (int i = 0; i < dw; i++) begin
      HREADY = 1'b0;
      HRESP  = err && (i == dw - 1);
      check_data_phase(g);
      @(posedge HCLK); @(negedge HCLK);
    end
    check_data_phase(g);
    HREADY = 1'b1;
    HRESP  = err;
    HRDATA = hrd;
    @(posedge HCLK); @(negedge HCLK);
    if (!m_we[g]) exp_rdata = hrd;
    check("ack", 64'(ack_o), 64'(4'b0001 << g));
    check("rdata", rdata_o, exp_rdata);
    check("err", 64'(err_o), 64'(err));
    check("resp_htrans", 64'(HTRANS), 64'd0);
    if (check_spacing) check("ack_spacing", 64'(cyc - last_ack_cyc), 64'd4);
    last_ack_cyc = cyc;
    last_grant   = g;
    req_i[g]     = 1'b0;
    HRESP        = 1'b0;
    HRDATA       = {$urandom, $urandom};
    @(posedge HCLK); @(negedge HCLK);
    check("idle_ack", 64'(ack_o), 64'd0);
    check("idle_htrans", 64'(HTRANS), 64'd0);
  endtask

  initial begin
    HRESETn     = 1'b0;
    req_i       = '0;
    req_we_i    = '0;
    req_addr_i  = '0;
    req_size_i  = '0;
    req_wdata_i = '0;
    HRDATA      = '0;
    HREADY      = 1'b1;
    HRESP       = 1'b0;
    last_grant  = N - 1;
    exp_rdata   = '0;
    last_ack_cyc = 0;

    // Reset values
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_htrans", 64'(HTRANS), 64'd0);
    check("rst_hsel", 64'(HSEL), 64'd0);
    check("rst_haddr", HADDR, 64'd0);
    check("rst_hwdata", HWDATA, 64'd0);
    check("rst_hwrite", 64'(HWRITE), 64'd0);
    check("rst_hsize", 64'(HSIZE), 64'd0);
    check("rst_hburst", 64'(HBURST), 64'd0);
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    check("idle_norq_htrans", 64'(HTRANS), 64'd0);

    // Single word write from requester 2
    add_req(2, 1'b1, 64'h1000, 3'b010, 64'hDEADBEEF);
    xfer(0, 0, 1'b0, {$urandom, $urandom}, 1'b0);

    // Read from requester 0 with three wait states
    add_req(0, 1'b0, 64'h2000, 3'b010, 64'h0);
    xfer(0, 3, 1'b0, 64'h55AA, 1'b0);

    // Put the pointer on requester 3, then all four contend
    add_random_req(3);
    xfer(0, 0, 1'b0, {$urandom, $urandom}, 1'b0);
    for (int k = 0; k < N; k++) add_random_req(k);
    for (int t = 0; t < 5; t++) begin
      int keep;
      keep = next_grant(req_i, last_grant);
      xfer(0, 0, 1'b0, {$urandom, $urandom}, t > 0);
      if (t < 4 && keep >= 0) add_random_req(keep);
    end
    for (int t = 0; t < N && req_i != 0; t++) xfer(0, 0, 1'b0, {$urandom, $urandom}, 1'b0);

    // ERROR response, then a normal transfer
    add_req(1, 1'b0, 64'h3000, 3'b011, 64'h0);
    xfer(0, 1, 1'b1, 64'hBAD0BAD0, 1'b0);
    add_req(2, 1'b1, 64'h4000, 3'b001, 64'h1234);
    xfer(0, 0, 1'b0, 64'h0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++)
        if (!req_i[k] && ($urandom_range(0, 2) == 0)) add_random_req(k);
      if (req_i == 0) add_random_req(int'($urandom_range(0, N - 1)));
      xfer(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 7) == 0), {$urandom, $urandom}, 1'b0);
    end
    for (int t = 0; t < N && req_i != 0; t++) xfer(0, 0, 1'b0, {$urandom, $urandom}, 1'b0);

    // Reset during the data phase of requester 1
    add_req(1, 1'b1, 64'hCAFE0000, 3'b010, 64'h77);
    @(posedge HCLK); @(negedge HCLK);
    check("mid_addr_htrans", 64'(HTRANS), 64'(2'b10));
    HREADY = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    HREADY = 1'b0;
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_htrans", 64'(HTRANS), 64'd0);
    check("mid_rst_hsel", 64'(HSEL), 64'd0);
    check("mid_rst_haddr", HADDR, 64'd0);
    check("mid_rst_hwdata", HWDATA, 64'd0);
    check("mid_rst_ack", 64'(ack_o), 64'd0);
    HREADY = 1'b1;
    repeat (3) begin
      @(posedge HCLK); @(negedge HCLK);
      check("in_rst_ack", 64'(ack_o), 64'd0);
    end
    last_grant = N - 1;
    exp_rdata  = '0;
    add_req(0, 1'b0, 64'h5000, 3'b010, 64'h0);
    HRESETn = 1'b1;
    xfer(0, 0, 1'b0, 64'hA5A5, 1'b0);
    xfer(0, 0, 1'b0, 64'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
